// File: rtl/shift_add_mult_seq_if.sv
// Operand/result bundle for the sequential shift-add multiplier.
// The requester drives start/sgn/D/Q; the multiplier drives busy/done/out.
interface shift_add_mult_seq_if #(
   parameter int M = 8,
   parameter int N = 8
);
   logic             start;
   logic             sgn;
   logic [M-1:0]     D;
   logic [N-1:0]     Q;
   logic             busy;
   logic             done;
   logic [M+N-1:0]   out;

   modport master (
      output start, sgn, D, Q,
      input  busy, done, out
   );

   modport slave (
      input  start, sgn, D, Q,
      output busy, done, out
   );
endinterface

// File: rtl/shift_add_mult_seq.sv
// Sequential shift-add multiplier, M x N bits, signed or unsigned per operation.
// Operands are reduced to magnitudes at capture, multiplied unsigned over N
// iterations, and the sign is re-applied in a final FIX cycle. Fixed latency:
// done is high N+1 clocks after the accepting start edge.
module shift_add_mult_seq #(
   parameter int M = 8,
   parameter int N = 8
) (
   input  logic                 clk,
   input  logic                 rst,
   shift_add_mult_seq_if.slave  bus
);

   localparam int CW = $clog2(N + 1);

   if (M < 2 || N < 2) begin : g_bad_params
      $error("shift_add_mult_seq: M and N must both be >= 2");
   end

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      FIX  = 2'd2
   } state_t;

   state_t          state;
   logic [M:0]      acc;      // partial-product high half, with carry bit
   logic [N-1:0]    qr;       // multiplier shift register, fills with product low bits
   logic [M-1:0]    dm;       // multiplicand magnitude
   logic [CW-1:0]   cnt;      // iterations completed
   logic            neg;      // result must be negated in FIX
   logic            busy_r;
   logic            done_r;
   logic [M+N-1:0]  out_r;

   logic [M-1:0]    d_mag;
   logic [N-1:0]    q_mag;
   logic [M:0]      sum;
   logic [M+N-1:0]  prod;
   logic [M+N-1:0]  result;
   logic            last;

   // Magnitude of the incoming operands. The most-negative value negates to
   // itself, which read as unsigned is exactly 2^(width-1), so no extra bit.
   assign d_mag  = (bus.sgn && bus.D[M-1]) ? (~bus.D + M'(1)) : bus.D;
   assign q_mag  = (bus.sgn && bus.Q[N-1]) ? (~bus.Q + N'(1)) : bus.Q;

   // One add step: conditionally add the multiplicand into the carry-extended
   // accumulator, then the FSM shifts {sum, qr} right by one.
   assign sum    = acc + (qr[0] ? {1'b0, dm} : {(M+1){1'b0}});
   assign last   = (cnt == CW'(N - 1));

   // After N shifts the product is {acc[M-1:0], qr}; the carry bit is always
   // clear by then because |D|*|Q| fits in M+N bits.
   assign prod   = {acc[M-1:0], qr};
   assign result = neg ? (~prod + (M+N)'(1)) : prod;

   assign bus.busy = busy_r;
   assign bus.done = done_r;
   assign bus.out  = out_r;

   // Control FSM and datapath registers; all outputs are registered.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state  <= IDLE;
         acc    <= '0;
         qr     <= '0;
         dm     <= '0;
         cnt    <= '0;
         neg    <= 1'b0;
         busy_r <= 1'b0;
         done_r <= 1'b0;
         out_r  <= '0;
      end else begin
         case (state)
            IDLE: begin
               // Also the done cycle: a start here chains back-to-back.
               done_r <= 1'b0;
               if (bus.start) begin
                  neg    <= bus.sgn & (bus.D[M-1] ^ bus.Q[N-1]);
                  dm     <= d_mag;
                  qr     <= q_mag;
                  acc    <= '0;
                  cnt    <= '0;
                  busy_r <= 1'b1;
                  state  <= CALC;
               end
            end
            CALC: begin
               acc <= {1'b0, sum[M:1]};
               qr  <= {sum[0], qr[N-1:1]};
               cnt <= cnt + CW'(1);
               if (last) begin
                  state <= FIX;
               end
            end
            FIX: begin
               out_r  <= result;
               done_r <= 1'b1;
               busy_r <= 1'b0;
               state  <= IDLE;
            end
            default: begin
               state  <= IDLE;
               busy_r <= 1'b0;
               done_r <= 1'b0;
            end
         endcase
      end
   end

endmodule
